// File: rtl/fwd_interlock_unit.sv
// Operand-forwarding and load-use interlock between decode and execute.
// Optional feature: define ZERO_REG_EN to hard-wire register 0 to zero.
module fwd_interlock_unit #(
    parameter int DSIZE      = 16,
    parameter int RSIZE      = 4,
    parameter int NREAD      = 2,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 0,
    parameter int LOAD_READY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [RSIZE-1:0]         issue_waddr,
    input  logic                     issue_is_load,
    input  logic [NREAD*RSIZE-1:0]   issue_raddr,
    input  logic [NREAD-1:0]         issue_ruse,
    input  logic [NREAD*DSIZE-1:0]   rf_rdata,
    input  logic [DEPTH*DSIZE-1:0]   stage_data,
    input  logic                     flush,
    output logic                     stall,
    output logic                     op_valid,
    output logic [NREAD*DSIZE-1:0]   op_data,
    output logic                     wb_en,
    output logic [RSIZE-1:0]         wb_addr,
    output logic [15:0]              stall_cnt
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DEPTH-1:0]            ent_valid_q, ent_valid_d;
    logic [DEPTH-1:0]            ent_wen_q, ent_wen_d;
    logic [DEPTH-1:0]            ent_load_q, ent_load_d;
    logic [DEPTH-1:0][RSIZE-1:0] ent_waddr_q, ent_waddr_d;
    logic                        op_valid_q, op_valid_d;
    logic [NREAD*DSIZE-1:0]      op_data_q, op_data_d;
    logic [15:0]                 stall_cnt_q, stall_cnt_d;
    logic [NREAD*DSIZE-1:0]      sel_data;
    logic [NREAD-1:0]            port_block;
    logic                        accept;

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        sel_data   = rf_rdata;
        port_block = '0;
        for (int p = 0; p < NREAD; p++) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (issue_ruse[p] && ent_valid_q[k] && ent_wen_q[k] &&
                    (ent_waddr_q[k] == issue_raddr[p*RSIZE +: RSIZE]) &&
                    !(ZERO_REG && (issue_raddr[p*RSIZE +: RSIZE] == '0))) begin
                    sel_data[p*DSIZE +: DSIZE] = stage_data[k*DSIZE +: DSIZE];
                    port_block[p] = (k < (ent_load_q[k] ? LOAD_READY : ALU_READY));
                end
            end
            if (ZERO_REG && (issue_raddr[p*RSIZE +: RSIZE] == '0)) begin
                sel_data[p*DSIZE +: DSIZE] = '0;
            end
        end
    end

    assign stall  = issue_valid & ~flush & (|port_block);
    assign accept = issue_valid & ~stall & ~flush;

    // Entries shift one stage per cycle; flush turns the old stage-0 entry into a bubble.
    always_comb begin
        ent_valid_d = '0;
        ent_wen_d   = '0;
        ent_load_d  = '0;
        ent_waddr_d = '0;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            ent_valid_d[k] = ent_valid_q[k-1];
            ent_wen_d[k]   = ent_wen_q[k-1];
            ent_load_d[k]  = ent_load_q[k-1];
            ent_waddr_d[k] = ent_waddr_q[k-1];
        end
        if (flush) begin
            ent_valid_d[1] = 1'b0;
            ent_wen_d[1]   = 1'b0;
            ent_load_d[1]  = 1'b0;
            ent_waddr_d[1] = '0;
        end
        if (accept) begin
            ent_valid_d[0] = 1'b1;
            ent_wen_d[0]   = issue_wen;
            ent_load_d[0]  = issue_is_load;
            ent_waddr_d[0] = issue_waddr;
        end
    end

    always_comb begin
        op_valid_d  = accept;
        op_data_d   = accept ? sel_data : op_data_q;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid_q <= '0;
            ent_wen_q   <= '0;
            ent_load_q  <= '0;
            ent_waddr_q <= '0;
            op_valid_q  <= 1'b0;
            op_data_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_valid_q <= ent_valid_d;
            ent_wen_q   <= ent_wen_d;
            ent_load_q  <= ent_load_d;
            ent_waddr_q <= ent_waddr_d;
            op_valid_q  <= op_valid_d;
            op_data_q   <= op_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign op_valid  = op_valid_q;
    assign op_data   = op_data_q;
    assign stall_cnt = stall_cnt_q;
    assign wb_addr   = ent_waddr_q[DEPTH-1];
    assign wb_en     = ent_valid_q[DEPTH-1] & ent_wen_q[DEPTH-1] &
                       ~(ZERO_REG & (ent_waddr_q[DEPTH-1] == '0));

endmodule

// File: tb/tb_fwd_interlock_unit.sv
// Bench for fwd_interlock_unit: per-cycle vector table plus hand-built flush,
// reset and register-0 sequences; registered operands go through a scoreboard queue.
module tb_fwd_interlock_unit;

`ifdef ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_wen;
    logic [3:0]  issue_waddr;
    logic        issue_is_load;
    logic [7:0]  issue_raddr;
    logic [1:0]  issue_ruse;
    logic [31:0] rf_rdata;
    logic [47:0] stage_data;
    logic        flush;
    logic        stall;
    logic        op_valid;
    logic [31:0] op_data;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] stall_cnt;

    typedef struct {
        logic        v;
        logic        wen;
        logic [3:0]  wa;
        logic        ld;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [1:0]  ruse;
        logic [15:0] rf0;
        logic [15:0] rf1;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] s2;
        logic        fl;
        logic        e_stall;
        logic [15:0] e_op0;
        logic [15:0] e_op1;
        logic        e_wb;
        logic [3:0]  e_wba;
    } vec_t;

    logic [32:0] exp_q[$];
    logic [15:0] model_cnt;
    int          n_checks;
    int          n_fail;
    vec_t        tbl[13];
    vec_t        t;

    fwd_interlock_unit dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_waddr  (issue_waddr),
        .issue_is_load(issue_is_load),
        .issue_raddr  (issue_raddr),
        .issue_ruse   (issue_ruse),
        .rf_rdata     (rf_rdata),
        .stage_data   (stage_data),
        .flush        (flush),
        .stall        (stall),
        .op_valid     (op_valid),
        .op_data      (op_data),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .stall_cnt    (stall_cnt)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t vec(
        input logic v, input logic wen, input logic [3:0] wa, input logic ld,
        input logic [3:0] ra0, input logic [3:0] ra1, input logic [1:0] ruse,
        input logic [15:0] rf0, input logic [15:0] rf1,
        input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
        input logic fl, input logic e_stall,
        input logic [15:0] e_op0, input logic [15:0] e_op1,
        input logic e_wb, input logic [3:0] e_wba);
        vec_t r;
        r.v = v; r.wen = wen; r.wa = wa; r.ld = ld;
        r.ra0 = ra0; r.ra1 = ra1; r.ruse = ruse;
        r.rf0 = rf0; r.rf1 = rf1; r.s0 = s0; r.s1 = s1; r.s2 = s2;
        r.fl = fl; r.e_stall = e_stall; r.e_op0 = e_op0; r.e_op1 = e_op1;
        r.e_wb = e_wb; r.e_wba = e_wba;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: one decode cycle. Called just after a rising edge.
    task automatic step(input vec_t v, input logic r);
        logic        acc;
        logic [32:0] e;
        rst           = r;
        issue_valid   = v.v;
        issue_wen     = v.wen;
        issue_waddr   = v.wa;
        issue_is_load = v.ld;
        issue_raddr   = {v.ra1, v.ra0};
        issue_ruse    = v.ruse;
        rf_rdata      = {v.rf1, v.rf0};
        stage_data    = {v.s2, v.s1, v.s0};
        flush         = v.fl;
        acc = v.v & ~v.e_stall & ~v.fl & ~r;
        exp_q.push_back({acc, v.e_op1, v.e_op0});
        if (r) model_cnt = 16'd0;
        else if (v.e_stall && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
        @(negedge clk);
        chk("stall", {31'd0, stall}, {31'd0, v.e_stall});
        chk("wb_en", {31'd0, wb_en}, {31'd0, v.e_wb});
        if (v.e_wb) chk("wb_addr", {28'd0, wb_addr}, {28'd0, v.e_wba});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("op_valid", {31'd0, op_valid}, {31'd0, e[32]});
        if (e[32]) chk("op_data", op_data, e[31:0]);
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, model_cnt});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_cnt     = 16'd0;
        rst           = 1'b1;
        issue_valid   = 1'b0;
        issue_wen     = 1'b0;
        issue_waddr   = 4'd0;
        issue_is_load = 1'b0;
        issue_raddr   = 8'hEE;
        issue_ruse    = 2'b00;
        rf_rdata      = 32'd0;
        stage_data    = 48'd0;
        flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_op_valid", {31'd0, op_valid}, 32'd0);
        chk("reset_op_data", op_data, 32'd0);
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset_wb_en", {31'd0, wb_en}, 32'd0);
        chk("reset_wb_addr", {28'd0, wb_addr}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);

        // ALU chain, load-use, priority, WB forwarding, unused port
        tbl[0]  = vec(1,1,4'd3,0, 4'hE,4'hE,2'b00, 16'h1111,16'h2222, 16'h0,16'h0,16'h0, 0,0, 16'h1111,16'h2222, 0,4'd0);
        tbl[1]  = vec(1,0,4'd0,0, 4'd3,4'hE,2'b01, 16'h5555,16'h6666, 16'h1234,16'h0,16'h0, 0,0, 16'h1234,16'h6666, 0,4'd0);
        tbl[2]  = vec(1,1,4'd5,1, 4'hE,4'hE,2'b00, 16'h0101,16'h0202, 16'h0,16'h0,16'h0, 0,0, 16'h0101,16'h0202, 0,4'd0);
        tbl[3]  = vec(1,0,4'd0,0, 4'd3,4'd5,2'b11, 16'h0303,16'h0404, 16'h0,16'hBEEF,16'h3333, 0,1, 16'h0,16'h0, 1,4'd3);
        tbl[4]  = vec(1,0,4'd0,0, 4'd3,4'd5,2'b11, 16'h0303,16'h0404, 16'h0,16'hBEEF,16'h3333, 0,0, 16'h0303,16'hBEEF, 0,4'd0);
        tbl[5]  = vec(1,1,4'd2,0, 4'hE,4'hE,2'b00, 16'h0A0A,16'h0B0B, 16'h0,16'h0,16'h0, 0,0, 16'h0A0A,16'h0B0B, 1,4'd5);
        tbl[6]  = vec(1,1,4'd2,0, 4'hE,4'hE,2'b00, 16'h0C0C,16'h0D0D, 16'h0,16'h0,16'h0, 0,0, 16'h0C0C,16'h0D0D, 0,4'd0);
        tbl[7]  = vec(1,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0E0E,16'h0F0F, 16'h0,16'h0,16'h0, 0,0, 16'h0E0E,16'h0F0F, 0,4'd0);
        tbl[8]  = vec(1,0,4'd0,0, 4'd2,4'd2,2'b11, 16'h0,16'h0, 16'h0,16'h0002,16'h0001, 0,0, 16'h0002,16'h0002, 1,4'd2);
        tbl[9]  = vec(1,0,4'd0,0, 4'd2,4'd2,2'b11, 16'h0,16'h0, 16'h0,16'h0,16'h00AA, 0,0, 16'h00AA,16'h00AA, 1,4'd2);
        tbl[10] = vec(1,0,4'd0,0, 4'd2,4'd2,2'b01, 16'h00CC,16'h00DD, 16'h0,16'h0,16'h00AA, 0,0, 16'h00CC,16'h00DD, 0,4'd0);
        tbl[11] = vec(1,1,4'd7,1, 4'hE,4'hE,2'b00, 16'h1010,16'h2020, 16'h0,16'h0,16'h0, 0,0, 16'h1010,16'h2020, 0,4'd0);
        tbl[12] = vec(1,0,4'd0,0, 4'd1,4'd7,2'b01, 16'h3030,16'h4040, 16'h0,16'h0,16'h0, 0,0, 16'h3030,16'h4040, 0,4'd0);
        for (int i = 0; i < 13; i++) step(tbl[i], 1'b0);

        // Flush during a load-use stall: the killed load must neither forward nor write back
        step(vec(1,1,4'd9,1, 4'hE,4'hE,2'b00, 16'h5050,16'h6060, 16'h0,16'h0,16'h0, 0,0, 16'h5050,16'h6060, 0,4'd0), 1'b0);
        step(vec(1,0,4'd0,0, 4'd9,4'hE,2'b01, 16'h7070,16'h8080, 16'h0,16'h0,16'h0, 1,0, 16'h0,16'h0, 1,4'd7), 1'b0);
        step(vec(1,0,4'd0,0, 4'd9,4'hE,2'b01, 16'h9090,16'hA0A0, 16'hDEAD,16'hDEAD,16'hDEAD, 0,0, 16'h9090,16'hA0A0, 0,4'd0), 1'b0);

        // Reset with three live writers in flight
        step(vec(1,1,4'd1,0, 4'hE,4'hE,2'b00, 16'h0001,16'h0002, 16'h0,16'h0,16'h0, 0,0, 16'h0001,16'h0002, 0,4'd0), 1'b0);
        step(vec(1,1,4'd2,0, 4'hE,4'hE,2'b00, 16'h0003,16'h0004, 16'h0,16'h0,16'h0, 0,0, 16'h0003,16'h0004, 0,4'd0), 1'b0);
        step(vec(1,1,4'd3,0, 4'hE,4'hE,2'b00, 16'h0005,16'h0006, 16'h0,16'h0,16'h0, 0,0, 16'h0005,16'h0006, 0,4'd0), 1'b0);
        step(vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0,16'h0, 16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, 1,4'd1), 1'b1);
        chk("rst_mid_op_data", op_data, 32'd0);
        chk("rst_mid_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_mid_wb_addr", {28'd0, wb_addr}, 32'd0);
        step(vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0,16'h0, 16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, 0,4'd0), 1'b0);
        step(vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0,16'h0, 16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, 0,4'd0), 1'b0);

        // Register 0: ordinary by default, hard-wired zero with ZERO_REG_EN
        step(vec(1,1,4'd0,0, 4'hE,4'hE,2'b00, 16'h0011,16'h0022, 16'h0,16'h0,16'h0, 0,0, 16'h0011,16'h0022, 0,4'd0), 1'b0);
        step(vec(1,0,4'd0,0, 4'd0,4'hE,2'b01, 16'h3333,16'h4444, 16'h7777,16'h0,16'h0, 0,0,
                 ZR ? 16'h0000 : 16'h7777, 16'h4444, 0,4'd0), 1'b0);
        step(vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0,16'h0, 16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, 0,4'd0), 1'b0);
        step(vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'h0,16'h0, 16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, !ZR,4'd0), 1'b0);

        // Random idle tail: bubbles only, so nothing may forward or stall
        for (int i = 0; i < 4; i++) begin
            t = vec(0,0,4'd0,0, 4'hE,4'hE,2'b00, 16'($urandom_range(0, 16'hFFFF)),16'h0,
                    16'h0,16'h0,16'h0, 0,0, 16'h0,16'h0, 0,4'd0);
            step(t, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_interlock_unit.md
# fwd_interlock_unit

Parametrised operand-forwarding and interlock unit for the pipelined datapath. It sits between decode and execute. It tracks every in-flight register write in a DEPTH-entry shift scoreboard and selects each source operand from the youngest matching pipeline stage or from the register file. It stalls decode only when the producing value is not yet available, as in a load-use dependency, and supports flush, multiple read ports and a stall-cycle counter.

## Interface
- DSIZE, 16, data width
- RSIZE, 4, register address width
- NREAD, 2, source operand ports
- DEPTH, 3, in-flight stages after decode (stage 0 = EX, DEPTH-1 = WB)
- ALU_READY, 0, first stage index where a non-load result is valid on stage_data
- LOAD_READY, 1, first stage index where load data is valid; legal only when 0 ≤ ALU_READY ≤ LOAD_READY ≤ DEPTH-1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- issue_valid  in  1  decode holds an instruction
- issue_wen  in  1  instruction writes a register
- issue_waddr  in  RSIZE  destination register
- issue_is_load  in  1  destination value comes from memory
- issue_raddr  in  NREAD*RSIZE  source registers, port p at [p*RSIZE +: RSIZE]
- issue_ruse  in  NREAD  port p actually read
- rf_rdata  in  NREAD*DSIZE  register file read data; excludes same-edge writes
- stage_data  in  DEPTH*DSIZE  result currently held or produced in stage k
- flush  in  1  kill stage-0 instruction and current decode
- stall  out  1  hold PC and decode this cycle
- op_valid  out  1  stage 0 holds a live instruction
- op_data  out  NREAD*DSIZE  registered forwarded operands for stage 0
- wb_en  out  1  stage DEPTH-1 live and writes
- wb_addr  out  RSIZE  stage DEPTH-1 destination
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Scoreboard entry k holds {valid, wen, waddr, is_load}. Every cycle e[k+1] <= e[k], and e[DEPTH-1] retires.
- e[0] is loaded with the decode instruction when accept = issue_valid & !stall & !flush. Otherwise e[0] is loaded with a bubble (valid=0).
- Match for port p at stage k: issue_ruse[p] & e[k].valid & e[k].wen & e[k].waddr == raddr[p].
- Only the youngest (lowest k) match is used.
- The matching entry is ready when k ≥ (is_load ? LOAD_READY : ALU_READY).
- Ready match: operand = stage_data[k]. No match: operand = rf_rdata[p].
- Not-ready youngest match: stall = issue_valid & !flush for that cycle. Older ready matches are ignored.
- On accept, op_data <= the selected operands and op_valid <= 1. On stall, bubble or flush, op_valid <= 0 and op_data holds its value.
- flush: e[0] advances to stage 1 as a bubble, op_valid <= 0 and the current issue is dropped. Flush takes priority over stall.
- wb_en / wb_addr are driven combinationally from e[DEPTH-1]. The register file writes at the edge that ends that cycle.
- stall_cnt increments on every cycle with stall=1 and saturates at 16'hFFFF.

## Timing
- Operand selection is combinational in the decode cycle. op_data is registered, with 1-cycle latency, aligned with stage 0.
- With ALU_READY=0, stage_data[0] is the live ALU output. The path op_data → ALU → mux → op_data register is legal because it passes through the register.
- Defaults give a 0-cycle penalty for ALU→use and a 1-cycle stall for load→use at distance 1.
- Stall depends only on current scoreboard state and inputs. A stalled instruction re-evaluates every cycle until it is ready.
- Reset value of every output, effective one cycle after rst is sampled high:
  - all entries are invalid
  - op_valid=0, op_data=0, stall_cnt=0
  - wb_en=0, wb_addr=0
  - stall=0
- Reset mid-operation discards all in-flight entries with no writeback.
- Same register written by two in-flight entries: the youngest wins.
- A port with issue_ruse=0 never matches or stalls. A bubble never matches.

## Configuration
- ZERO_REG_EN defined:
  - register 0 never matches, forwards or stalls
  - its operand is forced to 0
  - wb_en=0 for waddr 0
- ZERO_REG_EN undefined: register 0 is an ordinary register.

## Test plan
All scenarios use defaults (DSIZE=16, RSIZE=4, NREAD=2, DEPTH=3, ALU_READY=0, LOAD_READY=1).
- ALU chain: issue r3←ALU, next cycle issue read r3 with stage_data[0]=16'h1234 → stall=0, op_data port0=16'h1234 next cycle.
- Load-use: issue load r5, next cycle issue read r5 → stall=1 for 1 cycle. Then forward stage_data[1]=16'hBEEF, op_valid=1 one cycle after release, stall_cnt=1.
- Priority: r2 written at stage 2 (16'h0001) and stage 1 (16'h0002), issue reads r2 on both ports → both operands 16'h0002.
- WB forward: producer in stage 2, rf_rdata=16'h0000, stage_data[2]=16'h00AA → operand 16'h00AA. One cycle later, with no match, rf_rdata is used.
- Flush during load-use stall → stall=0, op_valid=0 next cycle, and stage 1 holds a bubble one cycle later.
- Reset with 3 live entries → wb_en=0, op_valid=0, stall_cnt=0 after reset. With ZERO_REG_EN, a read of r0 after a write to r0 gives 0 with no stall.
